// File: rtl/mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier controller.
// Combinational only: no latency and no backpressure.
package mul_pkg;

  localparam int WIDTH   = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mul_controller_if.sv
// Request, operand and datapath strobe bundle between a requester/datapath (master) and the controller (slave).
// Wires only: no latency; start is not queued while the controller is busy.
interface mul_controller_if #(
  parameter int WIDTH = mul_pkg::WIDTH
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             eqz;
  logic [WIDTH-1:0] bus_out;
  logic             ld_a;
  logic             ld_b;
  logic             ld_p;
  logic             clr_p;
  logic             dec_b;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, a_in, b_in, eqz,
    input  bus_out, ld_a, ld_b, ld_p, clr_p, dec_b, busy, done
  );

  modport slave (
    input  start, abort, a_in, b_in, eqz,
    output bus_out, ld_a, ld_b, ld_p, clr_p, dec_b, busy, done
  );

endinterface

// File: rtl/mul_operand_latch.sv
// Operand capture registers and the state-selected operand bus mux.
// Capture takes one edge; bus_out is combinational from state; no backpressure.
module mul_operand_latch
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  state_e           state,
  output logic [WIDTH-1:0] bus_out
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (capture) begin
      op_a <= a_in;
      op_b <= b_in;
    end
  end

  always_comb begin
    bus_out = '0;
    case (state)
      S_LOAD_A: bus_out = op_a;
      S_LOAD_B: bus_out = op_b;
      default:  bus_out = '0;
    endcase
  end

endmodule

// File: rtl/mul_controller.sv
// Repeated-addition multiplier sequencer: load A, load B, add/decrement until eqz, then pulse done.
// DONE is entered B+3 edges after start accept; start is ignored (not queued) while busy.
module mul_controller
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_controller_if.slave ctl
);

  state_e state;
  state_e state_nxt;
  logic   accept;
  logic   ld_a;
  logic   ld_b;
  logic   ld_p;
  logic   clr_p;
  logic   dec_b;
  logic   busy;
  logic   done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from state alone; only the ADD strobes look at eqz.
  always_comb begin
    state_nxt = S_IDLE;
    accept    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_p      = 1'b0;
    clr_p     = 1'b0;
    dec_b     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctl.start && !ctl.abort) begin
          accept    = 1'b1;
          state_nxt = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        ld_a      = 1'b1;
        busy      = 1'b1;
        state_nxt = ctl.abort ? S_IDLE : S_LOAD_B;
      end
      S_LOAD_B: begin
        ld_b      = 1'b1;
        clr_p     = 1'b1;
        busy      = 1'b1;
        state_nxt = ctl.abort ? S_IDLE : S_ADD;
      end
      S_ADD: begin
        busy  = 1'b1;
        ld_p  = !ctl.eqz;
        dec_b = !ctl.eqz;
        if (ctl.abort)    state_nxt = S_IDLE;
        else if (ctl.eqz) state_nxt = S_DONE;
        else              state_nxt = S_ADD;
      end
      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  mul_operand_latch #(
    .WIDTH (WIDTH)
  ) u_operand_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (accept),
    .a_in    (ctl.a_in),
    .b_in    (ctl.b_in),
    .state   (state),
    .bus_out (ctl.bus_out)
  );

  assign ctl.ld_a  = ld_a;
  assign ctl.ld_b  = ld_b;
  assign ctl.ld_p  = ld_p;
  assign ctl.clr_p = clr_p;
  assign ctl.dec_b = dec_b;
  assign ctl.busy  = busy;
  assign ctl.done  = done;

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench: controller plus a behavioural repeated-addition datapath (A, B counter, P).
module tb_mul_controller;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errs = 0;
  int   checks = 0;

  mul_controller_if #(.WIDTH(16)) m ();

  mul_controller #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (m)
  );

  always #5 clk = ~clk;

  // Datapath registers have no reset, like the real one.
  logic [15:0] dp_a, dp_b, dp_p;
  always @(posedge clk) begin
    if (m.ld_a) dp_a <= m.bus_out;
    if (m.ld_b)       dp_b <= m.bus_out;
    else if (m.dec_b) dp_b <= dp_b - 16'd1;
    if (m.clr_p)      dp_p <= '0;
    else if (m.ld_p)  dp_p <= dp_p + dp_a;
  end
  assign m.eqz = (dp_b == 16'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then counts edges until done; returns in the DONE cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag,
                        output logic [15:0] p, output int edges, output int adds,
                        output int busyc, output int ldac);
    m.a_in  = a;
    m.b_in  = b;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    edges = 0; adds = 0; busyc = 0; ldac = 0;
    while (!m.done && edges < 2000) begin
      if (m.busy) busyc++;
      if (m.ld_p) adds++;
      if (m.ld_a) ldac++;
      tick();
      edges++;
    end
    p = dp_p;
    chk({tag, "_done_seen"}, {31'd0, m.done}, 32'd1);
  endtask

  logic [15:0] p;
  int edges, adds, busyc, ldac;

  initial begin
    rst_n   = 1'b0;
    m.start = 1'b0;
    m.abort = 1'b0;
    m.a_in  = '0;
    m.b_in  = '0;
    #12;
    chk("rst_busy",  {31'd0, m.busy}, 32'd0);
    chk("rst_done",  {31'd0, m.done}, 32'd0);
    chk("rst_bus",   {16'd0, m.bus_out}, 32'd0);
    chk("rst_strobes", {27'd0, m.ld_a, m.ld_b, m.ld_p, m.clr_p, m.dec_b}, 32'd0);
    #6 rst_n = 1'b1;
    tick();

    // T1: a=7, b=5 with a cycle-by-cycle view of the strobes.
    m.a_in = 16'd7; m.b_in = 16'd5; m.start = 1'b1;
    tick();
    m.start = 1'b0;
    m.a_in = 16'd1; m.b_in = 16'd1;
    chk("t1_ld_a",   {31'd0, m.ld_a}, 32'd1);
    chk("t1_bus_a",  {16'd0, m.bus_out}, 32'd7);
    chk("t1_busy",   {31'd0, m.busy}, 32'd1);
    tick();
    chk("t1_ldb_clrp", {30'd0, m.ld_b, m.clr_p}, 32'd3);
    chk("t1_bus_b",  {16'd0, m.bus_out}, 32'd5);
    tick();
    chk("t1_add_bus", {16'd0, m.bus_out}, 32'd0);
    adds = 0; edges = 2;
    while (!m.done && edges < 50) begin
      if (m.ld_p && m.dec_b) adds++;
      tick();
      edges++;
    end
    chk("t1_adds",  adds, 32'd5);
    chk("t1_edges", edges, 32'd8);
    chk("t1_p",     {16'd0, dp_p}, 32'd35);
    tick();
    chk("t1_idle_busy", {31'd0, m.busy}, 32'd0);

    run_op(16'd7, 16'd5, "t1b", p, edges, adds, busyc, ldac);
    chk("t1_busy_cycles_before_done", busyc, 32'd8);
    chk("t1_done_busy", {31'd0, m.busy}, 32'd1);
    tick();

    // T2: zero operands.
    run_op(16'd9, 16'd0, "t2a", p, edges, adds, busyc, ldac);
    chk("t2a_edges", edges, 32'd3);
    chk("t2a_adds",  adds, 32'd0);
    chk("t2a_p",     {16'd0, p}, 32'd0);
    tick();
    run_op(16'd0, 16'd4, "t2b", p, edges, adds, busyc, ldac);
    chk("t2b_adds", adds, 32'd4);
    chk("t2b_p",    {16'd0, p}, 32'd0);
    tick();

    // T3: overflow truncation.
    run_op(16'd300, 16'd300, "t3", p, edges, adds, busyc, ldac);
    chk("t3_edges", edges, 32'd303);
    chk("t3_p",     {16'd0, p}, 32'd24464);
    tick();

    // T4: start held high; mid-run operand change.
    m.a_in = 16'd3; m.b_in = 16'd2; m.start = 1'b1;
    tick();
    edges = 0; ldac = 0;
    while (!m.done && edges < 50) begin
      if (m.ld_a) ldac++;
      if (edges == 2) m.a_in = 16'd11;
      tick();
      edges++;
    end
    chk("t4_edges", edges, 32'd5);
    chk("t4_one_accept", ldac, 32'd1);
    chk("t4_p", {16'd0, dp_p}, 32'd6);
    tick();
    chk("t4_idle_after_done", {31'd0, m.busy}, 32'd0);
    tick();
    m.start = 1'b0;
    chk("t4_reaccept_ld_a", {31'd0, m.ld_a}, 32'd1);
    chk("t4_reaccept_bus",  {16'd0, m.bus_out}, 32'd11);
    edges = 0;
    while (!m.done && edges < 50) begin
      tick();
      edges++;
    end
    chk("t4_second_p", {16'd0, dp_p}, 32'd22);
    tick();

    // Start and abort together in IDLE: no accept.
    m.a_in = 16'd5; m.b_in = 16'd5; m.start = 1'b1; m.abort = 1'b1;
    tick();
    m.start = 1'b0; m.abort = 1'b0;
    chk("start_abort_idle", {30'd0, m.busy, m.ld_a}, 32'd0);

    // T5: abort in the 2nd ADD cycle.
    m.a_in = 16'd7; m.b_in = 16'd5; m.start = 1'b1;
    tick();
    m.start = 1'b0;
    tick(); tick(); tick();
    chk("t5_in_add", {30'd0, m.ld_p, m.busy}, 32'd3);
    m.abort = 1'b1;
    tick();
    m.abort = 1'b0;
    chk("t5_aborted_idle", {30'd0, m.busy, m.done}, 32'd0);
    tick();
    chk("t5_no_done", {30'd0, m.busy, m.done}, 32'd0);
    run_op(16'd4, 16'd4, "t5", p, edges, adds, busyc, ldac);
    chk("t5_p", {16'd0, p}, 32'd16);
    // Abort raised in DONE: done stays high this cycle, then IDLE.
    m.abort = 1'b1;
    #1;
    chk("abort_in_done_done", {31'd0, m.done}, 32'd1);
    tick();
    m.abort = 1'b0;
    chk("abort_in_done_idle", {31'd0, m.busy}, 32'd0);

    // T6: asynchronous reset during ADD.
    m.a_in = 16'd9; m.b_in = 16'd9; m.start = 1'b1;
    tick();
    m.start = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre_busy", {31'd0, m.busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", {31'd0, m.busy}, 32'd0);
    chk("t6_async_strobes", {30'd0, m.ld_p, m.dec_b}, 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_op(16'd2, 16'd3, "t6", p, edges, adds, busyc, ldac);
    chk("t6_edges", edges, 32'd6);
    chk("t6_p", {16'd0, p}, 32'd6);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
